// File: rtl/md_sched.sv
// md_sched -- HI/LO multiply/divide scheduler.
//
// Accepts one mult/multu/div/divu/mthi/mtlo request per E-stage start pulse.
// Multiplies run for 5 cycles after the start cycle and divides for 10. hi/lo
// are written on the edge where the down-counter reaches zero. busy tells the
// hazard unit to stall D-stage HI/LO consumers.
//
// Configuration:
//   MD_SCHED_DIV_EN  defined   -> divide path (DIV state, div/divu) built in.
//                    undefined -> md_op 3/4 behave like md_op 0; no divider.
//
// Ports:
//   clk    in   1   single clock, rising edge
//   reset  in   1   asynchronous, active-low reset
//   start  in   1   E-stage pulse, md_op valid this cycle
//   md_op  in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 reserved
//   md_a   in  32   rs operand
//   md_b   in  32   rt operand
//   busy   out  1   stall request to the hazard unit
//   hi     out 32   HI register
//   lo     out 32   LO register
module md_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] a_r, b_r;
  logic        sign_r;
  logic        is_mul_s, is_div_s, done_s;

  logic signed [32:0] mul_a_s, mul_b_s;
  logic signed [65:0] prod_s;

  assign is_mul_s = start && ((md_op == 3'd1) || (md_op == 3'd2));
`ifdef MD_SCHED_DIV_EN
  assign is_div_s = start && ((md_op == 3'd3) || (md_op == 3'd4));
`else
  assign is_div_s = 1'b0;
`endif

  // busy covers the start cycle combinationally so the stall begins at once.
  assign busy = is_mul_s || is_div_s || (state_r != IDLE);

  // Multiplier: 33-bit extension lets one signed multiply serve mult and multu.
  assign mul_a_s = $signed({sign_r & a_r[31], a_r});
  assign mul_b_s = $signed({sign_r & b_r[31], b_r});
  assign prod_s  = mul_a_s * mul_b_s;

`ifdef MD_SCHED_DIV_EN
  logic        neg_a_s, neg_b_s;
  logic [31:0] abs_a_s, abs_b_s, uq_s, ur_s, div_q_s, div_r_s;

  // Sign-magnitude divide: truncating quotient, remainder takes dividend sign.
  // 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  always_comb begin
    neg_a_s = sign_r & a_r[31];
    neg_b_s = sign_r & b_r[31];
    abs_a_s = neg_a_s ? (32'd0 - a_r) : a_r;
    abs_b_s = neg_b_s ? (32'd0 - b_r) : b_r;
    if (abs_b_s != 32'd0) begin
      uq_s = abs_a_s / abs_b_s;
      ur_s = abs_a_s % abs_b_s;
    end else begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end
    div_q_s = (neg_a_s ^ neg_b_s) ? (32'd0 - uq_s) : uq_s;
    div_r_s = neg_a_s ? (32'd0 - ur_s) : ur_s;
  end
`endif

  // Next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (is_mul_s) begin
          state_s = MUL;
          cnt_s   = 4'd5;
        end else if (is_div_s) begin
          state_s = DIV;
          cnt_s   = 4'd10;
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Operand and sign-mode capture on an accepted mult/div start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r    <= 32'd0;
      b_r    <= 32'd0;
      sign_r <= 1'b0;
    end else if ((state_r == IDLE) && (is_mul_s || is_div_s)) begin
      a_r    <= md_a;
      b_r    <= md_b;
      sign_r <= (md_op == 3'd1) || (md_op == 3'd3);
    end else begin
      a_r    <= a_r;
      b_r    <= b_r;
      sign_r <= sign_r;
    end
  end

  // HI/LO update: operation completion or mthi/mtlo while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done_s) begin
      if (state_r == MUL) begin
        hi <= prod_s[63:32];
        lo <= prod_s[31:0];
`ifdef MD_SCHED_DIV_EN
      end else if (b_r != 32'd0) begin
        hi <= div_r_s;
        lo <= div_q_s;
`endif
      end else begin
        // Divide by zero: the full latency elapses but hi/lo are kept.
        hi <= hi;
        lo <= lo;
      end
    end else if ((state_r == IDLE) && start && (md_op == 3'd5)) begin
      hi <= md_a;
    end else if ((state_r == IDLE) && start && (md_op == 3'd6)) begin
      lo <= md_a;
    end else begin
      hi <= hi;
      lo <= lo;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected {hi, lo, busy length}
// records, a negedge monitor pops one whenever busy falls or an observation
// is requested for an operation that never raises busy.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .md_a  (md_a),
    .md_b  (md_b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t q[$];
  int   total   = 0;
  int   passed  = 0;
  logic obs_req = 1'b0;
  logic prev_busy = 1'b0;
  int   run_len = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: compare on busy falling edge or on an explicit observation slot.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      run_len++;
    end else if (prev_busy || obs_req) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_result: got hi=%h lo=%h want no transaction", hi, lo);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("busy_len", 32'(run_len), 32'(e.len));
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
      end
      run_len = 0;
    end
    prev_busy = busy;
  end

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int len);
    exp_t e;
    e.hi = h; e.lo = l; e.len = len;
    q.push_back(e);
  endtask

  // Present one start cycle; returns one cycle after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; md_a = a; md_b = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 40) begin
      total++;
      $display("FAIL busy_timeout: got busy stuck after %0d cycles want idle", n);
    end
    @(posedge clk); #1;
  endtask

  // Operation that never raises busy: request an observation the next cycle.
  task automatic issue_nobusy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    obs_req = 1'b1;
    @(posedge clk); #1;
    obs_req = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; md_op = 3'd0; md_a = 32'd0; md_b = 32'd0;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    push(32'hFFFFFFFF, 32'hFFFFFFFE, 6);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    wait_idle();

    push(32'h00000001, 32'hFFFFFFFE, 6);
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle();

    push(32'h12345678, 32'hFFFFFFFE, 0);
    issue_nobusy(3'd5, 32'h12345678, 32'd0);

    push(32'h12345678, 32'hCAFEF00D, 0);
    issue_nobusy(3'd6, 32'hCAFEF00D, 32'd0);

`ifdef MD_SCHED_DIV_EN
    push(32'h00000001, 32'hFFFFFFFD, 11);
    issue(3'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle();

    push(32'h00000001, 32'hFFFFFFFD, 11);
    issue(3'd3, 32'd9, 32'd0);
    wait_idle();

    push(32'h00000000, 32'h80000000, 11);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    push(32'h0000000F, 32'h0FFFFFFF, 11);
    issue(3'd4, 32'hFFFFFFFF, 32'h00000010);
    wait_idle();
`else
    push(32'h12345678, 32'hCAFEF00D, 0);
    issue_nobusy(3'd4, 32'd7, 32'd3);

    push(32'h12345678, 32'hCAFEF00D, 0);
    issue_nobusy(3'd3, 32'd100, 32'd5);
`endif

    push(32'h12345678, 32'hCAFEF00D, 0);
    issue_nobusy(3'd7, 32'hDEADBEEF, 32'd1);

    // Second start three cycles into a mult must be ignored.
    push(32'h00000000, 32'd30, 6);
    issue(3'd1, 32'd5, 32'd6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; md_op = 3'd1; md_a = 32'd3; md_b = 32'd3;
    @(posedge clk); #1 start = 1'b0; md_op = 3'd0;
    wait_idle();

    push(32'hFFFFFFFF, 32'hFFFFFFF1, 6);
    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    wait_idle();

    push(32'h40000000, 32'h00000000, 6);
    issue(3'd1, 32'h80000000, 32'h80000000);
    wait_idle();

    // Asynchronous reset when the counter has reached 4.
`ifdef MD_SCHED_DIV_EN
    push(32'd0, 32'd0, 7);
    issue(3'd3, 32'd100, 32'd7);
    repeat (6) @(posedge clk);
`else
    push(32'd0, 32'd0, 2);
    issue(3'd1, 32'd100, 32'd7);
    repeat (1) @(posedge clk);
`endif
    #2 reset = 1'b0;
    #1;
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_hi", hi, 32'd0);
    chk("async_lo", lo, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    push(32'd0, 32'd12, 6);
    issue(3'd1, 32'd3, 32'd4);
    wait_idle();

    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/md_sched.md
MD_SCHED -- requirements
Module: md_sched

Interface
REQ-001 The block SHALL have these ports; clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  E-stage pulse; an md_op is presented this cycle.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (ignored).
- md_a  in  32  rs operand.
- md_b  in  32  rt operand.
- busy  out  1  to the hazard unit; a D-stage HI/LO instruction stalls while this is high.
- hi  out  32  HI register, feeding the mfhi path.
- lo  out  32  LO register, feeding the mflo path.
REQ-002 Reset SHALL be asynchronous and active-low; there SHALL be exactly one clock, clk.

Function
REQ-003 The state machine SHALL have the states IDLE, MUL and DIV, with a 4-bit down-counter cnt.
REQ-004 In IDLE with start=1 and md_op = 1 or 2, the block SHALL latch the operands and sign mode, load cnt=5, and enter MUL.
REQ-005 In IDLE with start=1 and md_op = 3 or 4, the block SHALL latch the operands and sign mode, load cnt=10, and enter DIV.
REQ-006 In MUL or DIV, cnt SHALL decrement each cycle.
REQ-007 On the edge where cnt goes from 1 to 0, the block SHALL write hi and lo and return to IDLE.
REQ-008 busy SHALL equal (start and md_op in 1..4) OR (state != IDLE).
- Busy window: start cycle plus 5 cycles for mult, plus 10 cycles for div.
REQ-009 The new hi/lo values SHALL be visible in the cycle after busy falls.
REQ-010 For mult, the result SHALL be the signed 32x32 to 64-bit product; for multu, the unsigned product; in both cases hi = [63:32] and lo = [31:0].
REQ-011 For div, lo SHALL be the signed quotient truncated toward zero and hi SHALL be the remainder with the dividend's sign; divu SHALL use unsigned arithmetic.
REQ-012 For div or divu with md_b = 0, the block SHALL hold busy for the full count and leave hi and lo unchanged.
REQ-013 For signed div of 0x80000000 by 0xFFFFFFFF, the block SHALL produce lo = 0x80000000 and hi = 0.
REQ-014 mthi and mtlo SHALL write md_a into hi or lo on the next edge; they SHALL NOT assert busy, and they SHALL take effect only in IDLE.
REQ-015 A start arriving while state != IDLE SHALL be ignored, with no change to state, cnt or hi/lo (the hazard unit prevents this case).
REQ-016 md_op = 0 or 7 with start=1 SHALL cause no state change.
REQ-017 hi and lo SHALL change only on the events in REQ-007 and REQ-014.

Reset
REQ-018 When reset is low, the block SHALL immediately set state=IDLE, cnt=0, hi=0, lo=0 and busy=0 (busy still follows REQ-008 if start is asserted), whether or not an operation is in flight.
REQ-019 An operation interrupted by reset SHALL be discarded; after reset is released, the first start SHALL be accepted normally.

Configuration
REQ-020 The macro MD_SCHED_DIV_EN SHALL control whether the divide path is compiled in.
- Defined: the DIV state and the divide path exist as specified above.
- Undefined: md_op 3 and 4 SHALL be treated as md_op 0 (no busy, hi/lo unchanged) and no divider logic SHALL be synthesised.

Verification
REQ-021 mult scenario: start, md_op=1, md_a=0xFFFFFFFF, md_b=2 -> busy high for 6 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-022 multu scenario: start, md_op=2, same operands -> busy high for 6 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-023 div scenario (MD_SCHED_DIV_EN defined): start, md_op=3, md_a=7, md_b=0xFFFFFFFE -> busy high for 11 cycles, then lo=0xFFFFFFFD, hi=0x00000001.
- Divide by zero: md_b=0 -> busy high for 11 cycles, hi/lo unchanged.
REQ-024 Busy/idle protocol scenario:
- Second start with md_op=1 three cycles into a mult -> ignored, and the first result is intact.
- mthi with md_a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never high.
REQ-025 Reset scenario: reset pulled low asynchronously mid-div (cnt=4) -> hi=lo=0 and busy=0 without waiting for a clock edge.
- Then release reset and issue mult 3x4 -> lo=12 after 6 busy cycles.
REQ-026 Divider-absent scenario (MD_SCHED_DIV_EN undefined): start with md_op=4 -> busy never asserts and hi/lo are unchanged.
